// File: rtl/axil_to_wb_bridge.sv
// AXI4-Lite slave to Wishbone classic master bridge with one bus cycle in flight,
// round-robin read/write arbitration and SLVERR abort of cycles that never acknowledge.
module axil_to_wb_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255,
    localparam int STRB_WIDTH    = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [ADDR_WIDTH-1:0] s_awaddr,
    input  logic [2:0]            s_awprot,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    input  logic [DATA_WIDTH-1:0] s_wdata,
    input  logic [STRB_WIDTH-1:0] s_wstrb,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    output logic [1:0]            s_bresp,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    input  logic [ADDR_WIDTH-1:0] s_araddr,
    input  logic [2:0]            s_arprot,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    output logic [DATA_WIDTH-1:0] s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  core_cyc,
    output logic                  core_stb,
    output logic                  core_we,
    output logic [ADDR_WIDTH-1:0] core_addr,
    output logic [DATA_WIDTH-1:0] core_data_out,
    output logic [STRB_WIDTH-1:0] core_sel,
    input  logic [DATA_WIDTH-1:0] core_data_in,
    input  logic                  core_ack,
    input  logic                  core_err
);
    typedef enum logic [2:0] {IDLE, WR_BUS, RD_BUS, WR_RESP, RD_RESP} state_t;

    localparam int         CW          = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic       GRANT_READ  = 1'b0;

    state_t                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  aw_full_q, aw_full_d, w_full_q, w_full_d, ar_full_q, ar_full_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d, ar_addr_q, ar_addr_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [STRB_WIDTH-1:0] w_strb_q, w_strb_d;
    logic [CW-1:0]         tmo_cnt_q, tmo_cnt_d;
    logic                  core_cyc_q, core_cyc_d, core_we_q, core_we_d;
    logic [ADDR_WIDTH-1:0] core_addr_q, core_addr_d;
    logic [DATA_WIDTH-1:0] core_data_out_q, core_data_out_d;
    logic [STRB_WIDTH-1:0] core_sel_q, core_sel_d;
    logic                  s_bvalid_q, s_bvalid_d, s_rvalid_q, s_rvalid_d;
    logic [1:0]            s_bresp_q, s_bresp_d, s_rresp_q, s_rresp_d;
    logic [DATA_WIDTH-1:0] s_rdata_q, s_rdata_d;

    logic wr_pending, rd_pending, grant_wr, timed_out, bus_done, bus_ok;
    logic unused_prot;

    assign unused_prot = ^{s_awprot, s_arprot};
    assign wr_pending  = aw_full_q && w_full_q;
    assign rd_pending  = ar_full_q;
    // Contested grants go to whichever side did not win the previous contest.
    assign grant_wr    = wr_pending && (!rd_pending || (last_grant_q == GRANT_READ));
    assign timed_out   = (TIMEOUT_CYCLES != 0) && (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign bus_done    = core_err || core_ack || timed_out;
    assign bus_ok      = core_ack && !core_err;

    always_comb begin
        state_d         = state_q;
        last_grant_d    = last_grant_q;
        aw_full_d       = aw_full_q;
        aw_addr_d       = aw_addr_q;
        w_full_d        = w_full_q;
        w_data_d        = w_data_q;
        w_strb_d        = w_strb_q;
        ar_full_d       = ar_full_q;
        ar_addr_d       = ar_addr_q;
        tmo_cnt_d       = tmo_cnt_q;
        core_cyc_d      = core_cyc_q;
        core_we_d       = core_we_q;
        core_addr_d     = core_addr_q;
        core_data_out_d = core_data_out_q;
        core_sel_d      = core_sel_q;
        s_bvalid_d      = s_bvalid_q;
        s_bresp_d       = s_bresp_q;
        s_rvalid_d      = s_rvalid_q;
        s_rresp_d       = s_rresp_q;
        s_rdata_d       = s_rdata_q;

        if (s_awvalid && s_awready) begin
            aw_full_d = 1'b1;
            aw_addr_d = s_awaddr;
        end
        if (s_wvalid && s_wready) begin
            w_full_d = 1'b1;
            w_data_d = s_wdata;
            w_strb_d = s_wstrb;
        end
        if (s_arvalid && s_arready) begin
            ar_full_d = 1'b1;
            ar_addr_d = s_araddr;
        end

        case (state_q)
            IDLE: begin
                if (wr_pending && rd_pending) last_grant_d = grant_wr;
                if (grant_wr) begin
                    state_d         = WR_BUS;
                    tmo_cnt_d       = '0;
                    core_cyc_d      = 1'b1;
                    core_we_d       = 1'b1;
                    core_addr_d     = aw_addr_q;
                    core_data_out_d = w_data_q;
                    core_sel_d      = w_strb_q;
                end else if (rd_pending) begin
                    state_d         = RD_BUS;
                    tmo_cnt_d       = '0;
                    core_cyc_d      = 1'b1;
                    core_we_d       = 1'b0;
                    core_addr_d     = ar_addr_q;
                    core_data_out_d = '0;
                    core_sel_d      = '1;
                end
            end
            WR_BUS, RD_BUS: begin
                tmo_cnt_d = tmo_cnt_q + CW'(1);
                if (bus_done) begin
                    core_cyc_d = 1'b0;
                    core_we_d  = 1'b0;
                    if (state_q == WR_BUS) begin
                        state_d    = WR_RESP;
                        s_bvalid_d = 1'b1;
                        s_bresp_d  = bus_ok ? RESP_OKAY : RESP_SLVERR;
                        aw_full_d  = 1'b0;
                        w_full_d   = 1'b0;
                    end else begin
                        state_d    = RD_RESP;
                        s_rvalid_d = 1'b1;
                        s_rresp_d  = bus_ok ? RESP_OKAY : RESP_SLVERR;
                        s_rdata_d  = bus_ok ? core_data_in : '0;
                        ar_full_d  = 1'b0;
                    end
                end
            end
            WR_RESP: begin
                if (s_bready) begin
                    s_bvalid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            RD_RESP: begin
                if (s_rready) begin
                    s_rvalid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            last_grant_q    <= GRANT_READ;
            aw_full_q       <= 1'b0;
            aw_addr_q       <= '0;
            w_full_q        <= 1'b0;
            w_data_q        <= '0;
            w_strb_q        <= '0;
            ar_full_q       <= 1'b0;
            ar_addr_q       <= '0;
            tmo_cnt_q       <= '0;
            core_cyc_q      <= 1'b0;
            core_we_q       <= 1'b0;
            core_addr_q     <= '0;
            core_data_out_q <= '0;
            core_sel_q      <= '0;
            s_bvalid_q      <= 1'b0;
            s_bresp_q       <= 2'b00;
            s_rvalid_q      <= 1'b0;
            s_rresp_q       <= 2'b00;
            s_rdata_q       <= '0;
        end else begin
            state_q         <= state_d;
            last_grant_q    <= last_grant_d;
            aw_full_q       <= aw_full_d;
            aw_addr_q       <= aw_addr_d;
            w_full_q        <= w_full_d;
            w_data_q        <= w_data_d;
            w_strb_q        <= w_strb_d;
            ar_full_q       <= ar_full_d;
            ar_addr_q       <= ar_addr_d;
            tmo_cnt_q       <= tmo_cnt_d;
            core_cyc_q      <= core_cyc_d;
            core_we_q       <= core_we_d;
            core_addr_q     <= core_addr_d;
            core_data_out_q <= core_data_out_d;
            core_sel_q      <= core_sel_d;
            s_bvalid_q      <= s_bvalid_d;
            s_bresp_q       <= s_bresp_d;
            s_rvalid_q      <= s_rvalid_d;
            s_rresp_q       <= s_rresp_d;
            s_rdata_q       <= s_rdata_d;
        end
    end

    assign s_awready     = !aw_full_q;
    assign s_wready      = !w_full_q;
    assign s_arready     = !ar_full_q;
    assign s_bvalid      = s_bvalid_q;
    assign s_bresp       = s_bresp_q;
    assign s_rvalid      = s_rvalid_q;
    assign s_rresp       = s_rresp_q;
    assign s_rdata       = s_rdata_q;
    assign core_cyc      = core_cyc_q;
    assign core_stb      = core_cyc_q;
    assign core_we       = core_we_q;
    assign core_addr     = core_addr_q;
    assign core_data_out = core_data_out_q;
    assign core_sel      = core_sel_q;
endmodule

// File: tb/tb_axil_to_wb_bridge.sv
// Bench for axil_to_wb_bridge: memory-level reference model, Wishbone slave model,
// expected-response queues drained by independent monitors.
module tb_axil_to_wb_bridge;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_awvalid = 1'b0, s_awready;
    logic [31:0] s_awaddr = '0;
    logic [2:0]  s_awprot = '0;
    logic        s_wvalid = 1'b0, s_wready;
    logic [31:0] s_wdata = '0;
    logic [3:0]  s_wstrb = '0;
    logic        s_bvalid, s_bready = 1'b0;
    logic [1:0]  s_bresp;
    logic        s_arvalid = 1'b0, s_arready;
    logic [31:0] s_araddr = '0;
    logic [2:0]  s_arprot = '0;
    logic        s_rvalid, s_rready = 1'b0;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        core_cyc, core_stb, core_we;
    logic [31:0] core_addr, core_data_out;
    logic [3:0]  core_sel;
    logic [31:0] core_data_in = '0;
    logic        core_ack = 1'b0, core_err = 1'b0;

    axil_to_wb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awprot(s_awprot),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arprot(s_arprot),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .core_cyc(core_cyc), .core_stb(core_stb), .core_we(core_we), .core_addr(core_addr),
        .core_data_out(core_data_out), .core_sel(core_sel), .core_data_in(core_data_in),
        .core_ack(core_ack), .core_err(core_err)
    );

    always #5 clk = ~clk;

    int          n_vec = 0, n_err = 0;
    logic [68:0] bus_exp_q[$];   // {we, addr, wdata, sel}
    logic [1:0]  b_exp_q[$];     // bresp
    logic [33:0] r_exp_q[$];     // {rresp, rdata}
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] dev_mem[logic [31:0]];
    int          slave_mode = 0;  // 0 ack, 1 err, 2 never ack then late ack, 3 never ack
    int          slave_delay = 0;
    int          r_hold = 0;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    function automatic logic [31:0] dev_rd(input logic [31:0] a);
        return dev_mem.exists(a) ? dev_mem[a] : init_val(a);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drivers: called just after a rising edge; return just after the handshake edge.
    task automatic send_aw(input logic [31:0] a);
        bit ok = 1'b0;
        s_awvalid = 1'b1; s_awaddr = a;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk); ok = s_awready;
            @(posedge clk);
        end
        #1 s_awvalid = 1'b0;
        chk("aw_handshake", ok, 1);
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        bit ok = 1'b0;
        s_wvalid = 1'b1; s_wdata = d; s_wstrb = s;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk); ok = s_wready;
            @(posedge clk);
        end
        #1 s_wvalid = 1'b0;
        chk("w_handshake", ok, 1);
    endtask

    task automatic send_ar(input logic [31:0] a);
        bit ok = 1'b0;
        s_arvalid = 1'b1; s_araddr = a;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk); ok = s_arready;
            @(posedge clk);
        end
        #1 s_arvalid = 1'b0;
        chk("ar_handshake", ok, 1);
    endtask

    // order: 0 = AW and W together, 1 = AW delayed by gap cycles, 2 = W delayed by gap cycles
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int order, input int gap);
        bit ok = (slave_mode == 0);
        bus_exp_q.push_back({1'b1, a, d, s});
        b_exp_q.push_back(ok ? 2'b00 : 2'b10);
        if (ok) ref_mem[a] = merge(ref_rd(a), d, s);
        fork
            begin
                if (order == 2) begin repeat (gap) @(posedge clk); #1; end
                send_w(d, s);
            end
            begin
                if (order == 1) begin repeat (gap) @(posedge clk); #1; end
                send_aw(a);
            end
        join
    endtask

    task automatic do_read(input logic [31:0] a);
        bit ok = (slave_mode == 0);
        bus_exp_q.push_back({1'b0, a, 32'h0, 4'hF});
        r_exp_q.push_back({ok ? 2'b00 : 2'b10, ok ? ref_rd(a) : 32'h0});
        send_ar(a);
    endtask

    // Write and read presented in the same cycle; write_first is the expected grant order.
    task automatic issue_pair(input logic [31:0] wa, input logic [31:0] wd, input logic [31:0] ra,
                              input bit write_first);
        if (write_first) begin
            bus_exp_q.push_back({1'b1, wa, wd, 4'hF});
            ref_mem[wa] = wd;
            bus_exp_q.push_back({1'b0, ra, 32'h0, 4'hF});
            r_exp_q.push_back({2'b00, ref_rd(ra)});
        end else begin
            bus_exp_q.push_back({1'b0, ra, 32'h0, 4'hF});
            r_exp_q.push_back({2'b00, ref_rd(ra)});
            bus_exp_q.push_back({1'b1, wa, wd, 4'hF});
            ref_mem[wa] = wd;
        end
        b_exp_q.push_back(2'b00);
        fork
            send_aw(wa);
            send_w(wd, 4'hF);
            send_ar(ra);
        join
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            done = (bus_exp_q.size() == 0) && (b_exp_q.size() == 0) && (r_exp_q.size() == 0)
                   && !s_bvalid && !s_rvalid && !core_cyc;
        end
        chk("drain_within_budget", done, 1);
        @(posedge clk); #1;
    endtask

    task automatic check_latency(input string name);
        @(negedge clk); chk({name, "_cyc_low_at_handshake"}, core_cyc, 0);
        @(negedge clk); chk({name, "_cyc_high_next"}, core_cyc, 1);
    endtask

    // Wishbone slave model; also checks each bus cycle against the expected queue.
    initial begin : wb_slave
        bit          active = 1'b0;
        int          hi_cnt = 0;
        logic [68:0] e;
        logic [31:0] cur;
        forever begin
            @(posedge clk); #1;
            core_ack = 1'b0; core_err = 1'b0; core_data_in = $urandom;
            if (core_cyc && core_stb) begin
                if (!active) begin
                    active = 1'b1; hi_cnt = 0;
                    if (bus_exp_q.size() == 0) chk("bus_unexpected_cycle", 1, 0);
                    else begin
                        e = bus_exp_q.pop_front();
                        chk("bus_we", core_we, e[68]);
                        chk("bus_addr", core_addr, e[67:36]);
                        chk("bus_sel", core_sel, e[3:0]);
                        if (e[68]) chk("bus_wdata", core_data_out, e[35:4]);
                    end
                end
                hi_cnt++;
                if (slave_mode < 2 && hi_cnt - 1 == slave_delay) begin
                    if (slave_mode == 1) core_err = 1'b1;
                    else begin
                        core_ack = 1'b1;
                        cur = dev_rd(core_addr);
                        if (core_we) dev_mem[core_addr] = merge(cur, core_data_out, core_sel);
                        else core_data_in = cur;
                    end
                end
            end else if (active) begin
                active = 1'b0;
                if (slave_mode == 2) begin
                    chk("timeout_cyc_len", hi_cnt, TMO);
                    core_ack = 1'b1;
                    core_data_in = 32'hBAD0_BAD0;
                end
            end
        end
    end

    initial begin : ready_driver
        forever begin
            @(posedge clk); #1;
            if (s_rvalid && r_hold > 0) begin
                s_rready = 1'b0;
                r_hold--;
            end else s_rready = ($urandom_range(0, 3) != 0);
            s_bready = ($urandom_range(0, 3) != 0);
        end
    end

    // Response monitor: pops on each handshake and checks stability while stalled.
    initial begin : resp_mon
        bit          b_stall = 1'b0, r_stall = 1'b0;
        logic [1:0]  b_prev, be;
        logic [33:0] r_prev, re;
        forever begin
            @(negedge clk);
            if (rst) begin b_stall = 1'b0; r_stall = 1'b0; continue; end
            if (b_stall) begin
                chk("b_valid_held", s_bvalid, 1);
                if (s_bvalid) chk("b_resp_stable", s_bresp, b_prev);
            end
            b_stall = 1'b0;
            if (s_bvalid) begin
                if (s_bready) begin
                    if (b_exp_q.size() == 0) chk("b_unexpected", 1, 0);
                    else begin be = b_exp_q.pop_front(); chk("bresp", s_bresp, be); end
                end else begin b_stall = 1'b1; b_prev = s_bresp; end
            end
            if (r_stall) begin
                chk("r_valid_held", s_rvalid, 1);
                if (s_rvalid) chk("r_stable", {s_rresp, s_rdata}, r_prev);
            end
            r_stall = 1'b0;
            if (s_rvalid) begin
                if (s_rready) begin
                    if (r_exp_q.size() == 0) chk("r_unexpected", 1, 0);
                    else begin
                        re = r_exp_q.pop_front();
                        chk("rresp", s_rresp, re[33:32]);
                        chk("rdata", s_rdata, re[31:0]);
                    end
                end else begin r_stall = 1'b1; r_prev = {s_rresp, s_rdata}; end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $finish;
    end

    initial begin : main
        logic [31:0] a;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_core_cyc", core_cyc, 0);
        chk("rst_core_stb", core_stb, 0);
        chk("rst_core_we", core_we, 0);
        chk("rst_core_sel", core_sel, 0);
        chk("rst_bvalid", s_bvalid, 0);
        chk("rst_rvalid", s_rvalid, 0);
        chk("rst_rdata", s_rdata, 0);
        chk("rst_awready", s_awready, 1);
        chk("rst_wready", s_wready, 1);
        chk("rst_arready", s_arready, 1);
        @(posedge clk); #1;

        // Contention straight after reset: write first, then read first.
        issue_pair(32'h5000, 32'h1111_2222, 32'h5000, 1'b1);
        wait_idle();
        issue_pair(32'h5000, 32'h3333_4444, 32'h5000, 1'b0);
        wait_idle();

        slave_delay = 2;
        do_write(32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 0, 0);
        check_latency("single_wr");
        wait_idle();

        do_write(32'h0000_2004, 32'h1234_5678, 4'h3, 1, 3);
        check_latency("w_before_aw");
        wait_idle();

        ref_mem[32'h3000] = 32'hCAFE_F00D;
        dev_mem[32'h3000] = 32'hCAFE_F00D;
        slave_delay = 1;
        r_hold = 5;
        do_read(32'h3000);
        wait_idle();
        r_hold = 0;

        slave_mode = 1;
        do_read(32'h3000);
        wait_idle();

        slave_mode = 2;
        do_write(32'h0000_1000, 32'h0BAD_F00D, 4'hF, 0, 0);
        wait_idle();
        slave_mode = 0;
        do_read(32'h0000_1000);
        wait_idle();

        // Reset while a bus cycle hangs.
        slave_mode = 3;
        do_write(32'h6000, 32'hA5A5_A5A5, 4'hF, 0, 0);
        for (int i = 0; i < 20 && !core_cyc; i++) @(negedge clk);
        chk("rst_mid_cyc_seen", core_cyc, 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_core_cyc", core_cyc, 0);
        chk("rst_mid_core_stb", core_stb, 0);
        chk("rst_mid_bvalid", s_bvalid, 0);
        chk("rst_mid_awready", s_awready, 1);
        chk("rst_mid_wready", s_wready, 1);
        chk("rst_mid_arready", s_arready, 1);
        b_exp_q.delete();
        bus_exp_q.delete();
        slave_mode = 0;
        @(posedge clk); #1;
        do_write(32'h6000, 32'h0F0F_1234, 4'hF, 0, 0);
        wait_idle();
        do_read(32'h6000);
        wait_idle();

        repeat (60) begin
            a = 32'h4000 + 32'($urandom_range(0, 7) * 4);
            slave_delay = $urandom_range(0, 4);
            slave_mode = ($urandom_range(0, 7) == 0) ? 1 : 0;
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, 4'($urandom_range(1, 15)), $urandom_range(0, 2), $urandom_range(0, 3));
            else
                do_read(a);
            wait_idle();
        end
        slave_mode = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/axil_to_wb_bridge.md
Name: axil_to_wb_bridge

Overview:
- Parametrised AXI4-Lite slave to Wishbone classic master bridge.
- Lets AXI-Lite cores (e.g. mriscvcore) drive the Controller's core_* Wishbone bus in processorci_top.
- Decouples the AW and W channels, arbitrates reads against writes round-robin, and aborts bus cycles that never acknowledge with an error response.
- One Wishbone transaction is in flight at a time.

Parameters:
- ADDR_WIDTH, 32: AXI/Wishbone address width.
- DATA_WIDTH, 32: data width; 32 or 64 only; STRB_WIDTH = DATA_WIDTH/8 (derived).
- TIMEOUT_CYCLES, 255: maximum cycles waiting for ack/err; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_awvalid/s_awready  in/out  1  write-address handshake
- s_awaddr  in  ADDR_WIDTH  write address
- s_awprot  in  3  ignored
- s_wvalid/s_wready  in/out  1  write-data handshake
- s_wdata  in  DATA_WIDTH  write data
- s_wstrb  in  STRB_WIDTH  byte strobes
- s_bvalid  out  1  write response valid
- s_bready  in  1  write response accepted
- s_bresp  out  2  write response code
- s_arvalid/s_arready  in/out  1  read-address handshake
- s_araddr  in  ADDR_WIDTH  read address
- s_arprot  in  3  ignored
- s_rvalid  out  1  read data valid
- s_rready  in  1  read data accepted
- s_rdata  out  DATA_WIDTH  read data
- s_rresp  out  2  read response code
- core_cyc  out  1  Wishbone cycle
- core_stb  out  1  Wishbone strobe
- core_we  out  1  Wishbone write enable
- core_addr  out  ADDR_WIDTH  Wishbone address
- core_data_out  out  DATA_WIDTH  Wishbone write data
- core_sel  out  STRB_WIDTH  Wishbone byte select
- core_data_in  in  DATA_WIDTH  Wishbone read data
- core_ack  in  1  Wishbone acknowledge
- core_err  in  1  Wishbone error

Behaviour:
- Clocking and reset: one clock (clk), synchronous active-high reset (rst); all state updates on the rising edge of clk.
- Outputs in reset: all outputs 0, except s_awready, s_wready and s_arready, which are 1 in the first cycle after reset. Buffers empty, state IDLE, last_grant = READ, so the first contested grant goes to write.
- Input buffers: three one-entry holding registers (AW, W, AR).
  - Each xREADY = its buffer is empty.
  - A handshake (valid & ready) loads the buffer.
  - AW and W may arrive in either order or in the same cycle.
  - A buffer clears on the clock edge that enters the matching response state.
- FSM states: IDLE, WR_BUS, RD_BUS, WR_RESP, RD_RESP.
- IDLE:
  - write_ready = AW and W both held; read_ready = AR held.
  - Only one ready: go to that bus state.
  - Both ready: grant the opposite of last_grant and update last_grant.
  - On entering a bus state, register:
    - core_cyc = core_stb = 1
    - core_we = 1 for write
    - core_addr = buffered address, unmodified
    - core_data_out = wdata, core_sel = wstrb; for reads core_sel is all ones.
- Write latency: with AW and W accepted at edge N, core_cyc is high from edge N+1.
- WR_BUS / RD_BUS:
  - The timeout counter clears on entry and increments every cycle.
  - core_ack: drop cyc/stb/we on the next edge; go to the response state with resp = 2'b00 (OKAY). On a read, capture core_data_in into s_rdata on the same edge.
  - core_err (takes priority over ack if both are set): go to the response state with resp = 2'b10 (SLVERR). s_rdata = 0.
  - Timeout: if TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES-1 with no ack/err, behave exactly as for err (SLVERR, rdata 0). A late ack after the abort is ignored.
- WR_RESP: s_bvalid = 1 and s_bresp held stable until s_bready; on the handshake, s_bvalid drops and the state returns to IDLE.
- RD_RESP: s_rvalid/s_rdata/s_rresp are stable until s_rready; on the handshake, s_rvalid drops and the state returns to IDLE.
- Back-to-back: the next bus cycle may start on the edge after a response handshake. The minimum spacing between core_cyc assertions is 3 cycles (bus, resp, idle).
- Buffers filling during an active transaction: new AW/W/AR may be accepted while another transaction is active, as long as that buffer is empty. At most one of each channel is pending.
- Reset mid-transaction: on the next edge, cyc/stb drop, all buffers and responses are discarded, and the state returns to IDLE. No response is issued.
- The s_*prot inputs are unused.

Test Plan:
- Single write: AW 0x0000_1000 and W 0xDEADBEEF/strb 0xF in the same cycle, ack 2 cycles after cyc -> core_sel=0xF, core_data_out=0xDEADBEEF, core_cyc rises exactly 1 cycle after the handshake, bresp=00.
- W before AW: W 0x12345678/strb 0x3, then AW 0x2004 three cycles later -> no core_cyc until AW is accepted; core_sel=0x3, core_addr=0x2004, bresp=00.
- Read with backpressure: AR 0x3000, ack with core_data_in 0xCAFEF00D, s_rready held low 5 cycles -> rvalid and rdata=0xCAFEF00D stable 5 cycles, rresp=00, then IDLE.
- Contention: write and read both pending in IDLE after reset -> write granted first, read second; repeat with both pending -> read first (alternation).
- Error/timeout: core_err on a read -> rresp=10, rdata=0. TIMEOUT_CYCLES=8 with ack never asserted -> cyc drops after 8 bus cycles, bresp=10, and a late ack is ignored.
- Reset mid-op: assert rst while core_cyc=1 -> next cycle core_cyc=0, bvalid=0, all ready outputs =1; a following write completes normally.
